// File: rtl/layer_controller_neuron_done_pkg.sv
// Shared constants for the neuron-done layer controller: register map, latency FSM
// state encoding and the latency counter width.
package layer_controller_neuron_done_pkg;

   localparam int CNT_W = 32;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_LATENCY = 2'd1;
   localparam logic [1:0] ADDR_MASK    = 2'd2;
   localparam logic [1:0] ADDR_EDGE    = 2'd3;

   typedef logic [1:0] lat_state_t;

   localparam lat_state_t ST_IDLE = 2'd0;
   localparam lat_state_t ST_RUN  = 2'd1;
   localparam lat_state_t ST_DONE = 2'd2;

   // Saturating increment so a stalled layer never wraps back to a small latency.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/layer_controller_neuron_done_if.sv
// Avalon-MM slave bus bundle for the neuron-done layer controller.
interface layer_controller_neuron_done_if;
   import layer_controller_neuron_done_pkg::*;

   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [CNT_W-1:0] writedata;
   logic [CNT_W-1:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/layer_controller_sync2.sv
// Per-bit two-flop synchronizer bringing the asynchronous neuron-done levels into clk.
module layer_controller_sync2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] stable_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q   <= '0;
         stable_q <= '0;
      end else begin
         meta_q   <= d_i;
         stable_q <= meta_q;
      end
   end

   assign q_o = stable_q;

endmodule

// File: rtl/layer_controller_neuron_done.sv
// Neuron-done edge capture with a completion-latency counter behind an Avalon-MM slave.
// Define LAYER_CONTROLLER_NEURON_DONE_IRQ_EN to add the irq_mask register and level irq.
module layer_controller_neuron_done
   import layer_controller_neuron_done_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   layer_controller_neuron_done_if.slave bus,
   input  logic [WIDTH-1:0]             in_port,
   output logic                         irq
);

   logic [WIDTH-1:0] sync_data;
   logic [WIDTH-1:0] prev_q;
   logic [2:0]       prime_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
   logic [WIDTH-1:0] mask_rd;
   logic [CNT_W-1:0] count_q, count_d;
   lat_state_t       state_q, state_d;
   logic             wr, wr_edge, all_done;
   logic             unused_wdata;

   layer_controller_sync2 #(.WIDTH(WIDTH)) u_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (in_port),
      .q_o   (sync_data)
   );

   assign wr           = bus.chipselect & ~bus.write_n;
   assign wr_edge      = wr & (bus.address == ADDR_EDGE);
   assign all_done     = &edge_capture_q;
   assign unused_wdata = ^bus.writedata;

   // prime_q[2] is set once prev_q holds a sample taken after reset release,
   // so levels already high during reset are not mistaken for new edges.
   assign rise = sync_data & ~prev_q & {WIDTH{prime_q[2]}};

   always_comb begin
      edge_capture_d = edge_capture_q | rise;
      if (wr_edge) begin
         edge_capture_d = (edge_capture_q & ~bus.writedata[WIDTH-1:0]) | rise;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (wr_edge) begin
         state_d = ST_RUN;
         count_d = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (all_done) begin
                  state_d = ST_DONE;
               end else begin
                  count_d = sat_inc(count_q);
               end
            end
            ST_IDLE, ST_DONE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q         <= '0;
         prime_q        <= '0;
         edge_capture_q <= '0;
         count_q        <= '0;
         state_q        <= ST_IDLE;
      end else begin
         prev_q         <= sync_data;
         prime_q        <= {prime_q[1:0], 1'b1};
         edge_capture_q <= edge_capture_d;
         count_q        <= count_d;
         state_q        <= state_d;
      end
   end

`ifdef LAYER_CONTROLLER_NEURON_DONE_IRQ_EN
   logic [WIDTH-1:0] irq_mask_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask_q <= '0;
      end else if (wr && (bus.address == ADDR_MASK)) begin
         irq_mask_q <= bus.writedata[WIDTH-1:0];
      end
   end

   assign irq     = |(edge_capture_q & irq_mask_q);
   assign mask_rd = irq_mask_q;
`else
   assign irq     = 1'b0;
   assign mask_rd = '0;
`endif

   // Zero-wait-state read mux; bits above WIDTH read as zero.
   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA:    bus.readdata[WIDTH-1:0] = sync_data;
         ADDR_LATENCY: bus.readdata            = count_q;
         ADDR_MASK:    bus.readdata[WIDTH-1:0] = mask_rd;
         ADDR_EDGE:    bus.readdata[WIDTH-1:0] = edge_capture_q;
         default:      bus.readdata            = '0;
      endcase
   end

endmodule

// File: tb/tb_layer_controller_neuron_done.sv
// Self-checking bench for layer_controller_neuron_done; expectations follow the
// LAYER_CONTROLLER_NEURON_DONE_IRQ_EN setting used for the build.
module tb_layer_controller_neuron_done;
   import layer_controller_neuron_done_pkg::*;

   localparam int WIDTH = 8;
   localparam int LOGN  = 2048;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in_port;
   logic             irq;
   logic             checkEn;
   logic             forceReq;
   int               errors = 0;
   int               checks = 0;

   layer_controller_neuron_done_if busIf();

   layer_controller_neuron_done #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (busIf),
      .in_port (in_port),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_RUN, M_DONE} mstate_e;

   logic [WIDTH-1:0] inLog [0:LOGN-1];
   int               mN;
   logic [WIDTH-1:0] mCap;
   logic [WIDTH-1:0] mMask;
   logic [31:0]      mCount;
   mstate_e          mState;

   // Reference model: inLog[n] is in_port as seen at edge n after reset release;
   // a bit is captured at edge n when it was sampled 1 at edge n-2 and 0 at edge n-3.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mN     <= 0;
         mCap   <= '0;
         mMask  <= '0;
         mCount <= '0;
         mState <= M_IDLE;
      end else begin : step
         logic [WIDTH-1:0] riseM;
         logic [31:0]      base;
         logic             wr;
         riseM = '0;
         if (mN + 1 >= 4) riseM = inLog[(mN - 1) % LOGN] & ~inLog[(mN - 2) % LOGN];
         inLog[(mN + 1) % LOGN] <= in_port;
         mN <= mN + 1;
         wr   = busIf.chipselect && !busIf.write_n;
         base = forceReq ? 32'hFFFF_FFFE : mCount;
         if (wr && busIf.address == 2'd3) mCap <= (mCap & ~busIf.writedata[WIDTH-1:0]) | riseM;
         else                             mCap <= mCap | riseM;
`ifdef LAYER_CONTROLLER_NEURON_DONE_IRQ_EN
         if (wr && busIf.address == 2'd2) mMask <= busIf.writedata[WIDTH-1:0];
`endif
         if (wr && busIf.address == 2'd3) begin
            mState <= M_RUN;
            mCount <= 32'd0;
         end else if (mState == M_RUN) begin
            if (mCap == '1)                mState <= M_DONE;
            else if (base == 32'hFFFF_FFFF) mCount <= base;
            else                            mCount <= base + 32'd1;
         end
      end
   end

   function automatic logic [31:0] expRead(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0: if (mN >= 2) r[WIDTH-1:0] = inLog[(mN - 1) % LOGN];
         2'd1: r = forceReq ? 32'hFFFF_FFFE : mCount;
         2'd2: r[WIDTH-1:0] = mMask;
         default: r[WIDTH-1:0] = mCap;
      endcase
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("modelRead", busIf.readdata, expRead(busIf.address));
         checkOutput("modelIrq", {31'd0, irq}, {31'd0, |(mCap & mMask)});
      end
   end

   task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
      busIf.address    = a;
      busIf.writedata  = d;
      busIf.chipselect = 1'b1;
      busIf.write_n    = 1'b0;
      @(posedge clk);
      #1;
      busIf.chipselect = 1'b0;
      busIf.write_n    = 1'b1;
   endtask

   task automatic readExpect(input string name, input logic [1:0] a, input logic [31:0] exp);
      busIf.address = a;
      @(negedge clk);
      checkOutput(name, busIf.readdata, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [31:0] expMask;
   logic        expIrqOn;

   initial begin
`ifdef LAYER_CONTROLLER_NEURON_DONE_IRQ_EN
      expMask  = 32'h1;
      expIrqOn = 1'b1;
`else
      expMask  = 32'h0;
      expIrqOn = 1'b0;
`endif
      reset            = 1'b1;
      in_port          = '0;
      checkEn          = 1'b0;
      forceReq         = 1'b0;
      busIf.address    = 2'd0;
      busIf.chipselect = 1'b0;
      busIf.write_n    = 1'b1;
      busIf.writedata  = '0;
      idle(3);
      reset   = 1'b0;
      checkEn = 1'b1;

      for (int a = 0; a < 4; a++) readExpect("resetRead", 2'(a), 32'd0);
      checkOutput("resetIrq", {31'd0, irq}, 32'd0);
      idle(5);
      readExpect("idleCount", 2'd1, 32'd0);

      applyStimulus(2'd2, 32'h0000_0001);
      readExpect("maskRead", 2'd2, expMask);
      applyStimulus(2'd1, 32'h0000_1234);
      applyStimulus(2'd0, 32'h0000_00FF);
      readExpect("ignoredWrCount", 2'd1, 32'd0);
      readExpect("ignoredWrData", 2'd0, 32'd0);

      applyStimulus(2'd3, 32'h0000_00FF);
      for (int i = 0; i < WIDTH; i++) begin
         in_port[i] = 1'b1;
         idle(10);
      end
      idle(5);
      readExpect("latency73", 2'd1, 32'd73);
      readExpect("allCaptured", 2'd3, 32'h0000_00FF);
      readExpect("syncAllHigh", 2'd0, 32'h0000_00FF);
      idle(20);
      readExpect("doneHolds", 2'd1, 32'd73);

      in_port = '0;
      idle(5);
      applyStimulus(2'd3, 32'h0000_00FF);
      readExpect("clearAll", 2'd3, 32'd0);
      in_port[2] = 1'b1;
      idle(2);
      applyStimulus(2'd3, 32'h0000_0004);
      readExpect("setWinsClear", 2'd3, 32'h0000_0004);
      applyStimulus(2'd3, 32'h0000_0004);
      readExpect("w1cClear", 2'd3, 32'd0);

      in_port = '0;
      idle(5);
      in_port[1] = 1'b1;
      idle(4);
      checkOutput("irqMaskedBit", {31'd0, irq}, 32'd0);
      in_port[0] = 1'b1;
      idle(4);
      checkOutput("irqUnmaskedBit", {31'd0, irq}, {31'd0, expIrqOn});
      applyStimulus(2'd3, 32'h0000_0001);
      checkOutput("irqAfterClear", {31'd0, irq}, 32'd0);
      readExpect("capAfterIrqClear", 2'd3, 32'h0000_0002);

      in_port = '0;
      idle(5);
      applyStimulus(2'd3, 32'h0000_00FF);
      dut.count_q = 32'hFFFF_FFFE;
      forceReq    = 1'b1;
      idle(1);
      forceReq    = 1'b0;
      readExpect("saturate", 2'd1, 32'hFFFF_FFFF);
      idle(5);
      readExpect("saturateHold", 2'd1, 32'hFFFF_FFFF);

      applyStimulus(2'd3, 32'h0000_0000);
      idle(500);
      readExpect("count500", 2'd1, 32'd500);
      in_port = 8'h20;
      reset   = 1'b1;
      idle(3);
      reset   = 1'b0;
      readExpect("abortCount", 2'd1, 32'd0);
      readExpect("abortCapture", 2'd3, 32'd0);
      idle(10);
      readExpect("noStaleEdge", 2'd3, 32'd0);
      in_port = 8'h21;
      idle(5);
      readExpect("edgeAfterReset", 2'd3, 32'h0000_0001);
      idle(5);
      readExpect("idleAfterReset", 2'd1, 32'd0);

      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/layer_controller_neuron_done.md
LAYER_CONTROLLER_NEURON_DONE -- requirements
Module: layer_controller_neuron_done

Interface
REQ-001 Parameter WIDTH, default 8: number of neuron done lines; legal range 1..32.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  sole clock; every register samples on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  read data; zero wait states; read latency 0.
REQ-010 in_port  input  WIDTH  asynchronous neuron done levels.
REQ-011 irq  output  1  level interrupt to the controller CPU.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer; sync_data is the second stage.
REQ-013 A rising edge is defined as sync_data=1 with previous-cycle sync_data=0; detection SHALL be 3 cycles after the in_port change at the latest.
REQ-014 edge_capture[i] SHALL set on a rising edge of bit i and hold until cleared.
REQ-015 A write to address 3 SHALL clear every edge_capture bit whose writedata bit is 1 (write-1-to-clear).
REQ-016 If a set and a clear of the same bit occur in the same cycle, the set SHALL win.
REQ-017 Read map: addr 0 = sync_data; addr 1 = latency count; addr 2 = irq_mask; addr 3 = edge_capture. Unused upper bits read 0.
REQ-018 Writes to addr 0 and addr 1 SHALL be ignored.
REQ-019 The latency FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 Any addr-3 write SHALL reset the count to 0 and enter RUN, from any state.
REQ-021 In RUN, the count SHALL increment by 1 per cycle and saturate at 0xFFFFFFFF (no wrap).
REQ-022 When all WIDTH edge_capture bits are 1, RUN SHALL go to DONE; the count freezes, and the completing cycle is not counted.
REQ-023 DONE SHALL hold until the next addr-3 write; IDLE is left only by an addr-3 write.
REQ-024 A completion in the same cycle as an addr-3 write SHALL be superseded by the write: the FSM goes to RUN with the count at 0.

Reset
REQ-025 Reset SHALL clear the synchronizer, the edge-detect history, edge_capture, irq_mask and the count, set the FSM to IDLE, and drive irq to 0.
REQ-026 Reset asserted mid-RUN SHALL abort the measurement; there is no resume after release.
REQ-027 Edges present in the synchronizer at reset release SHALL NOT be captured until the history is refilled.

Configuration
REQ-028 The macro LAYER_CONTROLLER_NEURON_DONE_IRQ_EN SHALL select the interrupt feature.
REQ-029 With the macro defined: irq_mask (WIDTH bits) is written at addr 2, and irq = OR(edge_capture AND irq_mask) taken from registers, with no combinational path from the bus.
REQ-030 With the macro undefined: the irq_mask register is absent, addr 2 reads 0, addr-2 writes are ignored, and irq is tied to 0.

Structure
REQ-031 A shared package SHALL hold the address constants (DATA, LATENCY, MASK, EDGE), the FSM state typedef and the counter width constant of 32.
REQ-032 One sub-module, layer_controller_sync2, SHALL implement the per-bit 2-flop synchronizer, with WIDTH instances or one vector instance.

Verification
REQ-033 Reset, then read every address -> all reads 0, irq=0, FSM in IDLE.
REQ-034 Write addr3=0xFF, raise in_port bits 0..7 one per 10 cycles -> addr3 reads 0xFF, addr1 freezes at the completion cycle count (about 73), FSM in DONE.
REQ-035 Rising edge on bit 2 in the same cycle as an addr-3 write of 0x04 -> edge_capture bit 2 remains 1.
REQ-036 With the IRQ macro: mask=0x01, edge on bit 1 -> irq=0; then edge on bit 0 -> irq=1; write addr3=0x01 -> irq=0 on the next cycle.
REQ-037 Force the count to 0xFFFFFFFE with in_port held low -> the count reads 0xFFFFFFFF and stays there.
REQ-038 Assert reset mid-RUN with count 500 -> count=0, FSM in IDLE; a later edge sets edge_capture but the count does not advance.
